conv_window_buffer: RTL
=======================

Name: conv_window_buffer

Overview:
- Parametrised, double-buffered store for one convolution window: K*K pixel taps plus position tag (row, column) and four image-boundary flags.
- Sits between the line-buffer/window generator and the conv MAC array.
- Writer streams taps in order into one bank while the MAC array drains the other through a valid/ready handshake.
- Adds kernel-size/width generality, back-pressure, flush and overflow detection.

Parameters:
- DATA_W, 8, bits per pixel tap.
- K, 3, kernel edge (odd, 1..7); window holds NT = K*K taps.
- CNT_W, 15, width of row/column position counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wr_valid  in  1  tap presented
- wr_ready  out  1  buffer can accept a tap
- wr_data  in  DATA_W  tap value
- flush  in  1  discard partially filled bank
- pos_row  in  CNT_W  current row position
- pos_col  in  CNT_W  current column position
- zero_row, final_row, zero_col, final_col  in  1 each  boundary flags
- out_valid  out  1  complete window available
- out_ready  in  1  consumer accepts window
- out_window  out  NT*DATA_W  taps, tap 0 in MSB slice, tap NT-1 in LSB slice
- out_row, out_col  out  CNT_W  tag of presented window
- out_flags  out  4  {zero_row, final_row, zero_col, final_col} captured with window
- occupancy  out  2  number of full banks (0..2)
- err_overflow  out  1  sticky: tap offered while wr_ready low

Behaviour:
- Storage: two banks, each with NT tap registers, a row/column tag, a flags field and a full bit.
- Pointers: wr_bank, rd_bank, and fill index fidx (0..NT-1).
- Reset:
  - All tap, tag and flag registers cleared to 0; full bits 0.
  - wr_bank = rd_bank = 0, fidx = 0, err_overflow = 0.
  - Therefore out_valid = 0, wr_ready = 1, occupancy = 0, and out_window/out_row/out_col/out_flags = 0.
- Write:
  - wr_ready = !full[wr_bank], combinational.
  - On accept (wr_valid & wr_ready & !flush), wr_data is stored at tap fidx of wr_bank and fidx increments.
  - When the center tap (fidx == (NT-1)/2) is accepted, pos_row, pos_col and the four flags are captured into that bank's tag, in the same edge.
  - When tap NT-1 is accepted, full[wr_bank] is set, fidx returns to 0 and wr_bank toggles, all in the same edge.
- Read:
  - out_valid = full[rd_bank].
  - out_window, out_row, out_col and out_flags are driven from the rd_bank registers, stable while out_valid is high and out_ready is low.
  - On pop (out_valid & out_ready), full[rd_bank] is cleared and rd_bank toggles.
  - Bank contents are not cleared on pop.
- Latency: last tap accepted at edge N with rd_bank == that bank gives out_valid high in the cycle after edge N.
- Throughput: one window per NT cycles sustained when out_ready is held high.
- Simultaneous events:
  - Completing a fill and a pop in the same cycle act on different banks; both take effect and occupancy is unchanged.
  - A pop of a full wr_bank in the same cycle as a write attempt: the write is still refused, because wr_ready is evaluated before the pop.
- Flush:
  - Sets fidx to 0 and keeps wr_bank; full banks and their contents are untouched.
  - flush with wr_valid in the same cycle: the tap is discarded and err_overflow is not set.
  - flush with tap count 0 is a no-op.
- Overflow:
  - wr_valid & !wr_ready & !flush sets err_overflow; the tap is dropped and fidx is unchanged.
  - err_overflow is cleared only by reset.
- occupancy = full[0] + full[1].
- Reset mid-fill or mid-hold: all state returns to reset values at that edge and any partial window is lost.
- For K = 1 the center tap and the last tap coincide; tag capture and completion happen in the same edge.

Test Plan:
- K=3: stream taps 0x11..0x99 with pos_row=4, pos_col=7 at the center tap and flags 4'b1010, out_ready=1 -> out_valid one cycle after the ninth tap; out_window=0x112233445566778899, out_row=4, out_col=7, out_flags=1010.
- out_ready=0: stream 27 taps -> occupancy reaches 2 after tap 18; wr_ready=0 from then; tap 19 is dropped and err_overflow=1; outputs hold window 1. Raise out_ready -> window 1 then window 2 popped in order.
- Write 5 taps, pulse flush, then write 9 taps A0..A8 -> output window is exactly A0..A8, tagged with the position present at tap A4.
- Continuous stream of 4 windows with out_ready=1 -> out_valid pulses every 9 cycles, occupancy never exceeds 1, no err_overflow.
- Assert reset while one bank is full and 4 taps are pending -> next cycle out_valid=0, occupancy=0, wr_ready=1, out_window=0, err_overflow=0.
- K=5, DATA_W=8: 25-tap stream -> 200-bit out_window with tap 0 in bits [199:192]; tag captured at tap 12.

Source files
------------

// File: rtl/conv_window_buffer.sv
// Double-buffered convolution window store: one bank is filled tap by tap while the other
// is presented to the MAC array through a valid/ready handshake.
module conv_window_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned CNT_W  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      flush_i,
  input  logic [CNT_W-1:0]          pos_row_i,
  input  logic [CNT_W-1:0]          pos_col_i,
  input  logic                      zero_row_i,
  input  logic                      final_row_i,
  input  logic                      zero_col_i,
  input  logic                      final_col_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [K*K*DATA_W-1:0]     out_window_o,
  output logic [CNT_W-1:0]          out_row_o,
  output logic [CNT_W-1:0]          out_col_o,
  output logic [3:0]                out_flags_o,
  output logic [1:0]                occupancy_o,
  output logic                      err_overflow_o
);

  localparam int unsigned NT = K * K;
  localparam int unsigned FW = (NT > 1) ? $clog2(NT) : 1;
  localparam logic [FW-1:0] LastIdx   = FW'(NT - 1);
  localparam logic [FW-1:0] CenterIdx = FW'((NT - 1) / 2);

  logic [DATA_W-1:0] tap_q   [2][NT];
  logic [CNT_W-1:0]  row_q   [2];
  logic [CNT_W-1:0]  col_q   [2];
  logic [3:0]        flags_q [2];

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [FW-1:0] fidx_q, fidx_d;
  logic          err_q, err_d;

  logic accept, pop;

  // wr_ready is taken from the pre-pop state, so a bank freed this cycle cannot be refilled
  // until the next one.
  assign wr_ready_o = ~full_q[wr_bank_q];
  assign accept     = wr_valid_i & wr_ready_o & ~flush_i;
  assign pop        = full_q[rd_bank_q] & out_ready_i;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    fidx_d    = fidx_q;
    err_d     = err_q;
    if (pop) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (flush_i) begin
      fidx_d = '0;
    end else if (accept) begin
      if (fidx_q == LastIdx) begin
        fidx_d            = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        fidx_d = fidx_q + 1'b1;
      end
    end
    if (wr_valid_i && !wr_ready_o && !flush_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      fidx_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      fidx_q    <= fidx_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < int'(NT); t++) begin
          tap_q[b][t] <= '0;
        end
        row_q[b]   <= '0;
        col_q[b]   <= '0;
        flags_q[b] <= '0;
      end
    end else if (accept) begin
      tap_q[wr_bank_q][fidx_q] <= wr_data_i;
      // Tag follows the centre tap; for K = 1 this is also the completing tap.
      if (fidx_q == CenterIdx) begin
        row_q[wr_bank_q]   <= pos_row_i;
        col_q[wr_bank_q]   <= pos_col_i;
        flags_q[wr_bank_q] <= {zero_row_i, final_row_i, zero_col_i, final_col_i};
      end
    end
  end

  always_comb begin
    out_window_o = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      out_window_o[(NT-1-i)*DATA_W +: DATA_W] = tap_q[rd_bank_q][i];
    end
  end

  assign out_valid_o    = full_q[rd_bank_q];
  assign out_row_o      = row_q[rd_bank_q];
  assign out_col_o      = col_q[rd_bank_q];
  assign out_flags_o    = flags_q[rd_bank_q];
  assign occupancy_o    = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign err_overflow_o = err_q;

endmodule
